fetch_queue: RTL
================

# fetch_queue

Instruction buffer between the instruction fetch unit and the decode stage of the RV32I pipeline. It accepts fetched {PC, instruction} pairs from fetch and presents them in order to decode over a valid/ready handshake, absorbing decode stalls so fetch can run ahead by up to DEPTH instructions. A flush input discards all buffered instructions on a taken branch, jump or trap redirect.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- XLEN, 32, width of the PC and instruction fields
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries; highest priority
- if_valid_i  in  1  fetch presents a valid pair
- if_pc_i  in  XLEN  PC of the presented instruction
- if_instr_i  in  XLEN  presented instruction word
- if_ready_o  out  1  queue can accept a pair this cycle
- id_valid_o  out  1  head entry is valid for decode
- id_pc_o  out  XLEN  PC of the head entry
- id_instr_o  out  XLEN  instruction of the head entry
- id_ready_i  in  1  decode consumes the head this cycle
- count_o  out  clog2(DEPTH)+1  number of occupied entries

## Operation
- State: DEPTH-entry storage array of {pc, instr}, write pointer wr_ptr, read pointer rd_ptr (clog2(DEPTH) bits each, wrap naturally modulo DEPTH), and occupancy count (0..DEPTH).
- push = if_valid_i & if_ready_o & ~flush_i: writes {if_pc_i, if_instr_i} at wr_ptr; wr_ptr increments.
- pop = id_valid_o & id_ready_i & ~flush_i: rd_ptr increments.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- if_ready_o = (count != DEPTH). It does not depend on id_ready_i, so there is no combinational path from decode to fetch. When the queue is full, fetch stalls even if decode pops in the same cycle.
- id_valid_o = (count != 0).
- id_pc_o and id_instr_o are driven from the head entry when id_valid_o=1. When empty they are forced to 0 and 32'h0000_0013 (ADDI x0,x0,0, the canonical NOP).
- flush_i=1: on the next edge wr_ptr, rd_ptr and count are cleared to 0. Any push or pop offered in that cycle is ignored, and the stored data is left stale. If flush_i and a push are both offered, the pushed pair is dropped.
- Storage words are not reset. The outputs are still defined after reset because the queue reports empty.
- Handshake rules: fetch must hold if_pc_i and if_instr_i stable while if_valid_i=1 and if_ready_o=0. The queue holds the id_* outputs stable while id_valid_o=1 and id_ready_i=0.

## Timing
- Reset (reset_i=0, asynchronous): count_o=0, id_valid_o=0, if_ready_o=1, id_pc_o=0, id_instr_o=32'h0000_0013. The queue leaves reset on the first rising edge after reset_i returns to 1.
- Latency: a pair pushed into an empty queue at edge N appears on id_* with id_valid_o=1 immediately after edge N. The fall-through is one cycle; there is no bypass in the same cycle.
- Throughput: one push and one pop per cycle, sustained.
- Full (count=DEPTH): if_ready_o=0. A pop at edge N raises if_ready_o after edge N.
- Empty (count=0): a push-and-pop in the same cycle is impossible because id_valid_o=0. count becomes 1.
- Wrap-around: both pointers roll from DEPTH-1 to 0 with no bubble.
- Reset asserted mid-operation: all state clears asynchronously, without waiting for a clock edge.

## Test plan
- Reset: assert reset_i=0 at t=0, release at 130 ns -> count_o=0, id_valid_o=0, if_ready_o=1, id_instr_o=0x00000013 throughout reset.
- Fill with id_ready_i=0: push PCs 0x0, 0x4, 0x8, 0xC with instructions 0x00500093, 0x00A00113, 0x002081B3, 0x40208233 -> count_o reaches 4, if_ready_o=0 after the 4th edge, head stays PC 0x0 / 0x00500093.
- Drain in order: from the full state, set id_ready_i=1 for four cycles -> PCs 0x0, 0x4, 0x8, 0xC appear in order. Then id_valid_o=0 and id_instr_o=0x00000013.
- Streaming wrap-around: push and pop 10 consecutive instructions at PCs 0x00..0x24 -> decode sees all 10 in order with no bubble, count_o stays 1.
- Flush with simultaneous push: with count_o=3, assert flush_i=1 while pushing PC 0x100 -> the next cycle has count_o=0 and id_valid_o=0. A following push of PC 0x200 becomes the new head one edge later.
- Mid-operation reset: with count_o=2, drive reset_i=0 between clock edges -> count_o=0 and id_valid_o=0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for the instruction fetch queue
//
// Groups every non-clock, non-reset signal of fetch_queue.
//   master : the side that drives fetch data, flush and decode ready (fetch/decode stages or a bench)
//   slave  : the queue itself
// Signals:
//   flush_i     discard all buffered entries (highest priority)
//   if_valid_i  fetch presents a {pc, instr} pair
//   if_pc_i     PC of the presented instruction
//   if_instr_i  presented instruction word
//   if_ready_o  queue can accept a pair this cycle
//   id_valid_o  head entry is valid for decode
//   id_pc_o     PC of the head entry
//   id_instr_o  instruction of the head entry
//   id_ready_i  decode consumes the head this cycle
//   count_o     number of occupied entries
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush_i;
    logic            if_valid_i;
    logic [XLEN-1:0] if_pc_i;
    logic [XLEN-1:0] if_instr_i;
    logic            if_ready_o;
    logic            id_valid_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_instr_o;
    logic            id_ready_i;
    logic [CW-1:0]   count_o;

    modport master (
        output flush_i, if_valid_i, if_pc_i, if_instr_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_instr_o, count_o
    );

    modport slave (
        input  flush_i, if_valid_i, if_pc_i, if_instr_i, id_ready_i,
        output if_ready_o, id_valid_o, id_pc_o, id_instr_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction buffer between fetch and decode with flush
//
// Buffers up to DEPTH {pc, instr} pairs so fetch can run ahead of a stalled decode.
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   reset_i  asynchronous active-low reset
//   bus      fetch_queue_if.slave (fetch push side, decode pop side, flush, count)
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    // Ready is derived from occupancy only, so decode ready never reaches fetch
    // combinationally; a full queue stalls fetch even if decode pops that cycle.
    assign bus.if_ready_o = (count != CW'(DEPTH));
    assign bus.id_valid_o = (count != '0);
    assign bus.count_o    = count;

    assign push = bus.if_valid_i & bus.if_ready_o & ~bus.flush_i;
    assign pop  = bus.id_valid_o & bus.id_ready_i & ~bus.flush_i;

    // Empty queue presents PC 0 and a NOP rather than stale storage contents.
    assign bus.id_pc_o    = bus.id_valid_o ? pc_mem[rd_ptr]    : '0;
    assign bus.id_instr_o = bus.id_valid_o ? instr_mem[rd_ptr] : NOP;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            // Stored words are left stale; clearing count makes them unreachable.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage has no reset: validity is tracked entirely by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.if_pc_i;
            instr_mem[wr_ptr] <= bus.if_instr_i;
        end
    end
endmodule
